// File: rtl/wave_display_pkg.sv
// Shared definitions for the waveform overlay: controller states, sample
// store geometry, the "no data" sample code and the per-pixel trace test.
package wave_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } wave_state_t;

  localparam int         WAVE_POINTS = 300;
  localparam logic [8:0] WAVE_LAST   = 9'd299;
  localparam logic [7:0] WAVE_BLANK  = 8'd255;

  // True when a pixel at amplitude row 'row' lies on the trace segment
  // joining sample 'prev' (column-1) and sample 'cur' (column). Column 0
  // has no left neighbour and lights only its own sample point.
  function automatic logic trace_hit(input logic [7:0] prev,
                                     input logic [7:0] cur,
                                     input logic [7:0] row,
                                     input logic       first_col);
    logic [7:0] lo;
    logic [7:0] hi;
    if (first_col) begin
      return (cur != WAVE_BLANK) && (row == cur);
    end
    if ((prev == WAVE_BLANK) || (cur == WAVE_BLANK)) begin
      return 1'b0;
    end
    lo = (prev < cur) ? prev : cur;
    hi = (prev < cur) ? cur : prev;
    return (row >= lo) && (row <= hi);
  endfunction

endpackage

// File: rtl/wave_line_buf.sv
// One line of waveform samples: 300 x 8 RAM, single write port and a
// registered read port. Contents are deliberately not reset.
module wave_line_buf
  import wave_display_pkg::*;
(
  input  logic       lcd_clk,
  input  logic       i_we,
  input  logic [8:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [8:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [0:WAVE_POINTS-1];
  logic [7:0] r_rdata;

  // Write captured samples; read is registered to map onto block RAM.
  always_ff @(posedge lcd_clk) begin
    if (i_we && (i_waddr <= WAVE_LAST)) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wave_display.sv
// Waveform overlay for the LCD raster. Once per frame the 300 samples are
// copied from the external store into a back buffer; a completed copy is
// swapped to the front and drawn as a connected trace over a 300 x 256
// window. The front buffer is only ever replaced by a complete pass, so an
// aborted or in-progress fetch never disturbs what is on screen.
//
// state | meaning
// IDLE  | waiting for frame_start
// FETCH | issuing read addresses 0..299 to the sample store
// FLUSH | waiting RD_LAT cycles for the last sample to land
// DRAW  | front buffer valid, waiting for the window's last pixel
// DONE  | one-cycle lcd_wr_over pulse
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [10:0] WAVE_X0    = 11'd10,
  parameter logic [10:0] WAVE_Y0    = 11'd20,
  parameter int          RD_LAT     = 1,       // 1..3
  parameter logic [15:0] WAVE_COLOR = 16'hFFE0,
  parameter logic [15:0] BG_COLOR   = 16'h0000
) (
  input  logic        lcd_clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic        wave_data_req,
  output logic [8:0]  wave_rd_addr,
  input  logic [7:0]  wave_rd_data,
  output logic [15:0] pixel_data,
  output logic        lcd_wr_over
);

  localparam logic [1:0]  FLUSH_INIT = 2'(RD_LAT - 1);
  localparam logic [10:0] END_X      = WAVE_X0 + 11'(WAVE_LAST);
  localparam logic [10:0] END_Y      = WAVE_Y0 + 11'd255;

  wave_state_t r_state;
  logic        r_req;
  logic [8:0]  r_addr;
  logic        r_over;
  logic [1:0]  r_flush_cnt;
  logic        r_bank;        // bank currently displayed; the other is filled
  logic        r_buf_valid;

  logic        r_cap_vld  [RD_LAT];
  logic [8:0]  r_cap_addr [RD_LAT];

  logic        w_we0;
  logic        w_we1;
  logic [7:0]  w_rd0;
  logic [7:0]  w_rd1;
  logic [7:0]  w_rdata;

  logic [10:0] w_col;
  logic [10:0] w_row;
  logic        w_in;
  logic [8:0]  w_raddr;

  logic        r_s1_in;
  logic        r_s1_first;
  logic [7:0]  r_s1_row;
  logic        r_s1_bank;
  logic [7:0]  r_prev;
  logic [15:0] r_pix;

  // Sequencer: fetch, flush, buffer swap, end-of-window detection.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_over      <= 1'b0;
      r_flush_cnt <= '0;
      r_bank      <= 1'b0;
      r_buf_valid <= 1'b0;
    end else begin
      r_over <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
            r_addr  <= '0;
          end
        end
        ST_FETCH: begin
          if (frame_start) begin
            r_addr <= '0;
          end else if (r_addr == WAVE_LAST) begin
            r_state     <= ST_FLUSH;
            r_req       <= 1'b0;
            r_flush_cnt <= FLUSH_INIT;
          end else begin
            r_addr <= r_addr + 9'd1;
          end
        end
        ST_FLUSH: begin
          if (frame_start) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
            r_addr  <= '0;
          end else if (r_flush_cnt == 2'd0) begin
            // Sample 299 is written on this same edge, so the swap is safe.
            r_state     <= ST_DRAW;
            r_bank      <= ~r_bank;
            r_buf_valid <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
          end
        end
        ST_DRAW: begin
          if (frame_start) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
            r_addr  <= '0;
          end else if ((pixel_xpos == END_X) && (pixel_ypos == END_Y)) begin
            r_state <= ST_DONE;
            r_over  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay each issued address by RD_LAT so it lines up with returned data.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_cap_vld[i]  <= 1'b0;
        r_cap_addr[i] <= '0;
      end
    end else begin
      r_cap_vld[0]  <= r_req;
      r_cap_addr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_cap_vld[i]  <= r_cap_vld[i-1];
        r_cap_addr[i] <= r_cap_addr[i-1];
      end
    end
  end

  assign w_we0 = r_cap_vld[RD_LAT-1] &  r_bank;
  assign w_we1 = r_cap_vld[RD_LAT-1] & ~r_bank;

  // Window-relative coordinates; negative offsets wrap and fall outside.
  assign w_col   = pixel_xpos - WAVE_X0;
  assign w_row   = pixel_ypos - WAVE_Y0;
  assign w_in    = (w_col <= 11'(WAVE_LAST)) && (w_row <= 11'd255);
  assign w_raddr = w_in ? w_col[8:0] : 9'd0;

  wave_line_buf u_buf0 (
    .lcd_clk (lcd_clk),
    .i_we    (w_we0),
    .i_waddr (r_cap_addr[RD_LAT-1]),
    .i_wdata (wave_rd_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rd0)
  );

  wave_line_buf u_buf1 (
    .lcd_clk (lcd_clk),
    .i_we    (w_we1),
    .i_waddr (r_cap_addr[RD_LAT-1]),
    .i_wdata (wave_rd_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rd1)
  );

  assign w_rdata = r_s1_bank ? w_rd1 : w_rd0;

  // Pixel stage 1: align window flags with the registered RAM read.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_in    <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_row   <= '0;
      r_s1_bank  <= 1'b0;
    end else begin
      r_s1_in    <= w_in & r_buf_valid;
      r_s1_first <= (w_col == 11'd0);
      r_s1_row   <= w_row[7:0];
      r_s1_bank  <= r_bank;
    end
  end

  // Pixel stage 2: trace test against the previous column's sample, which
  // is simply last cycle's read because xpos advances one per clock.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= WAVE_BLANK;
      r_pix  <= BG_COLOR;
    end else begin
      r_prev <= w_rdata;
      r_pix  <= (r_s1_in && trace_hit(r_prev, w_rdata, r_s1_row, r_s1_first))
                ? WAVE_COLOR : BG_COLOR;
    end
  end

  assign wave_data_req = r_req;
  assign wave_rd_addr  = r_addr;
  assign lcd_wr_over   = r_over;
  assign pixel_data    = r_pix;

endmodule

// File: doc/wave_display.md
WAVE_DISPLAY -- requirements
Module: wave_display

Interface
REQ-001 Parameter WAVE_X0, default 11'd10: screen column of waveform sample 0.
REQ-002 Parameter WAVE_Y0, default 11'd20: screen row of amplitude code 0, the top of the 256-row window.
REQ-003 Parameter RD_LAT, default 1: lcd_clk cycles from wave_rd_addr to valid wave_rd_data, range 1..3.
REQ-004 Parameter WAVE_COLOR, default 16'hFFE0; parameter BG_COLOR, default 16'h0000. Both are RGB565.
REQ-005 lcd_clk  in  1  pixel clock; the only clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_start  in  1  one-cycle pulse at the start of vertical blanking.
REQ-008 pixel_xpos  in  11  current raster column; increments by 1 per lcd_clk within a line.
REQ-009 pixel_ypos  in  11  current raster row.
REQ-010 wave_data_req  out  1  read enable to the sample store.
REQ-011 wave_rd_addr  out  9  sample index 0..299.
REQ-012 wave_rd_data  in  8  sample from the store; 255 means "no data / out of range".
REQ-013 pixel_data  out  16  RGB565 pixel for the coordinate presented 2 cycles earlier.
REQ-014 lcd_wr_over  out  1  one-cycle pulse: waveform window fully drawn, store may re-arm.

Function
REQ-015 States: IDLE, FETCH, FLUSH, DRAW, DONE.
REQ-016 IDLE -> FETCH on frame_start.
REQ-017 FETCH: drive wave_data_req=1 and wave_rd_addr=0,1,...,299, one address per cycle. After address 299, go to FLUSH.
REQ-018 Capture: the data returned RD_LAT cycles after address n is written to local buffer buf[n] (300x8).
REQ-019 FLUSH: wave_data_req=0. Hold RD_LAT cycles until buf[299] is written, then go to DRAW.
REQ-020 DRAW: when (pixel_xpos,pixel_ypos)=(WAVE_X0+299, WAVE_Y0+255) is observed, go to DONE.
REQ-021 DONE: lcd_wr_over=1 for exactly one cycle, then IDLE.
REQ-022 frame_start in FETCH, FLUSH or DRAW aborts the current pass and restarts FETCH at address 0. No lcd_wr_over is issued for the aborted pass.
REQ-023 wave_data_req=0 and wave_rd_addr holds its last value in every state except FETCH.
REQ-024 Window: col = pixel_xpos - WAVE_X0 and row = pixel_ypos - WAVE_Y0. A pixel is inside the window when 0<=col<=299 and 0<=row<=255, using unsigned compares on 11-bit values.
REQ-025 Trace rule, col>0: the pixel is WAVE_COLOR when min(buf[col-1],buf[col]) <= row <= max(buf[col-1],buf[col]) and neither sample is 255.
REQ-026 Trace rule, col=0: the pixel is WAVE_COLOR when row == buf[0] and buf[0] != 255.
REQ-027 Every other pixel is BG_COLOR.
REQ-028 The previous-column sample is kept in a register updated as col advances. A new line, or any col=0, reloads that register.
REQ-029 pixel_data latency is exactly 2 cycles from pixel coordinates, in all states.
REQ-030 The buffer contents drawn are those of the last completed FETCH. Before the first completed FETCH, every pixel is BG_COLOR.

Reset
REQ-031 rst_n low: state=IDLE, wave_data_req=0, wave_rd_addr=0, lcd_wr_over=0, pixel_data=BG_COLOR.
REQ-032 rst_n low: buffer valid flag=0. Buffer RAM contents are not reset.
REQ-033 Reset deassertion mid-frame: the block waits in IDLE for the next frame_start.

Structure
REQ-034 Shared package holds: the state encoding, WAVE_POINTS=300, WAVE_LAST=299, and the blank code 8'd255.
REQ-035 One sub-module, wave_line_buf: a 300x8 RAM, single write port, registered read port, clocked by lcd_clk.

Verification
REQ-036 Model store returns data = addr[7:0], RD_LAT=1, then frame_start. Required: wave_data_req high for exactly 300 cycles, addresses 0..299 in order, and lcd_wr_over pulses once after pixel (309,275).
REQ-037 buf[10]=40 and buf[11]=60. Required: column x=21 is WAVE_COLOR for rows 60..80 and BG_COLOR for rows 59 and 81.
REQ-038 buf[0..149]=255 and all other samples 128. Required: columns 10..160 are all BG_COLOR; column 161 is WAVE_COLOR only at row 148.
REQ-039 frame_start asserted again at address 150 of FETCH. Required: addresses restart at 0, and no lcd_wr_over precedes the completed pass.
REQ-040 RD_LAT=3, model returns addr[7:0]^8'hA5. Required: captured buf[n] == n^8'hA5 for all n; FLUSH lasts 3 cycles.
REQ-041 rst_n pulsed low during DRAW. Required: outputs take their reset values within 0 cycles (async). With no frame_start, no wave_data_req and no lcd_wr_over follow.
